// File: rtl/sd_spi_engine_if.sv
// rtl/sd_spi_engine_if.sv - register-block / card-pin bus of the SD SPI shift engine
interface sd_spi_engine_if #(
   parameter int DIV_WIDTH = 8
);
   logic                 START;
   logic                 ABORT;
   logic                 WIDE;
   logic [DIV_WIDTH-1:0] DIV;
   logic [15:0]          TX_DATA;
   logic                 MISO;
   logic [15:0]          RX_DATA;
   logic                 BUSY;
   logic                 DONE;
   logic                 SCLK;
   logic                 MOSI;

   // register-block side: issues transfers, collects results
   modport master (
      output START, ABORT, WIDE, DIV, TX_DATA,
      input  RX_DATA, BUSY, DONE
   );

   // shift-engine side: owns the SPI pins
   modport slave (
      input  START, ABORT, WIDE, DIV, TX_DATA, MISO,
      output RX_DATA, BUSY, DONE, SCLK, MOSI
   );

   // card side: sees the clock and data out, returns MISO
   modport card (
      input  SCLK, MOSI,
      output MISO
   );
endinterface

// File: rtl/sd_spi_engine.sv
// rtl/sd_spi_engine.sv - SPI mode-0 bit shift engine for 8/16-bit SD transfers
module sd_spi_engine #(
   parameter int DIV_WIDTH = 8
) (
   input  logic           C100M,
   input  logic           RESET_n,
   sd_spi_engine_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

   localparam logic [DIV_WIDTH-1:0] C_CNT_ONE = DIV_WIDTH'(1);

   state_t               r_state, w_next_state;
   logic [15:0]          r_tx, w_tx;
   logic [15:0]          r_rx, w_rx;
   logic [15:0]          r_rx_data, w_rx_data;
   logic [4:0]           r_bits, w_bits;
   logic [DIV_WIDTH-1:0] r_cnt, w_cnt;
   logic [DIV_WIDTH-1:0] r_div, w_div;
   logic                 r_wide, w_wide;
   logic                 r_sclk, w_sclk;
   logic                 r_mosi, w_mosi;
   logic                 r_done, w_done;
   logic                 w_cnt_zero;
   logic                 w_last_bit;
   logic [15:0]          w_tx_shift;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_last_bit = (r_bits == 5'd1);
   // rotate rather than shift in zero so every tx bit stays observed
   assign w_tx_shift = {r_tx[14:0], r_tx[15]};

   // state register
   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // next-state: ABORT overrides everything, including a simultaneous START
   always_comb begin
      w_next_state = r_state;
      if (bus.ABORT) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (bus.START) w_next_state = S_LOW;
            S_LOW:   if (w_cnt_zero) w_next_state = S_HIGH;
            S_HIGH:  if (w_cnt_zero) w_next_state = w_last_bit ? S_IDLE : S_LOW;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // datapath next values: latch at START, sample MISO on SCLK rise, shift on SCLK fall
   always_comb begin
      w_tx      = r_tx;
      w_rx      = r_rx;
      w_rx_data = r_rx_data;
      w_bits    = r_bits;
      w_cnt     = r_cnt;
      w_div     = r_div;
      w_wide    = r_wide;
      w_sclk    = r_sclk;
      w_mosi    = r_mosi;
      w_done    = 1'b0;
      if (bus.ABORT) begin
         w_sclk = 1'b0;
         w_mosi = 1'b1;
         w_cnt  = '0;
         w_bits = 5'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.START) begin
                  w_div  = bus.DIV;
                  w_wide = bus.WIDE;
                  w_tx   = bus.TX_DATA;
                  w_bits = bus.WIDE ? 5'd16 : 5'd8;
                  w_mosi = bus.WIDE ? bus.TX_DATA[15] : bus.TX_DATA[7];
                  w_cnt  = bus.DIV;
               end
            end
            S_LOW: begin
               if (!w_cnt_zero) begin
                  w_cnt = r_cnt - C_CNT_ONE;
               end else begin
                  w_sclk = 1'b1;
                  w_rx   = {r_rx[14:0], bus.MISO};
                  w_cnt  = r_div;
               end
            end
            S_HIGH: begin
               if (!w_cnt_zero) begin
                  w_cnt = r_cnt - C_CNT_ONE;
               end else begin
                  w_sclk = 1'b0;
                  w_bits = r_bits - 5'd1;
                  if (!w_last_bit) begin
                     w_tx   = w_tx_shift;
                     w_mosi = r_wide ? w_tx_shift[15] : w_tx_shift[7];
                     w_cnt  = r_div;
                  end else begin
                     w_done    = 1'b1;
                     w_mosi    = 1'b1;
                     w_rx_data = r_wide ? r_rx : {8'h00, r_rx[7:0]};
                  end
               end
            end
            default: begin
               w_sclk = 1'b0;
               w_mosi = 1'b1;
            end
         endcase
      end
   end

   // datapath registers; MOSI idles high, everything else clears
   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_tx      <= 16'h0000;
         r_rx      <= 16'h0000;
         r_rx_data <= 16'h0000;
         r_bits    <= 5'd0;
         r_cnt     <= '0;
         r_div     <= '0;
         r_wide    <= 1'b0;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_tx      <= w_tx;
         r_rx      <= w_rx;
         r_rx_data <= w_rx_data;
         r_bits    <= w_bits;
         r_cnt     <= w_cnt;
         r_div     <= w_div;
         r_wide    <= w_wide;
         r_sclk    <= w_sclk;
         r_mosi    <= w_mosi;
         r_done    <= w_done;
      end
   end

   assign bus.RX_DATA = r_rx_data;
   assign bus.BUSY    = (r_state != S_IDLE);
   assign bus.DONE    = r_done;
   assign bus.SCLK    = r_sclk;
   assign bus.MOSI    = r_mosi;

endmodule

// File: tb/tb_sd_spi_engine.sv
// tb/tb_sd_spi_engine.sv - directed self-checking bench for sd_spi_engine
module tb_sd_spi_engine;

   logic clk;
   logic rst_n;
   logic loop_en;
   logic miso_tie;

   int n_checks;
   int n_errors;

   sd_spi_engine_if #(.DIV_WIDTH(8)) bus ();

   sd_spi_engine #(.DIV_WIDTH(8)) dut (
      .C100M   (clk),
      .RESET_n (rst_n),
      .bus     (bus)
   );

   assign bus.MISO = loop_en ? bus.MOSI : miso_tie;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // present a transfer and return just after E0, the edge that samples START
   task automatic start_xfer(input logic wide, input logic [7:0] div, input logic [15:0] tx);
      @(negedge clk);
      bus.WIDE    = wide;
      bus.DIV     = div;
      bus.TX_DATA = tx;
      bus.START   = 1'b1;
      @(posedge clk);
      #1 bus.START = 1'b0;
   endtask

   // sample each cycle t after E0+t; optionally disturb the inputs mid-transfer
   task automatic monitor(input int budget, input logic disturb,
                          output int first_rise, output int period, output int rises,
                          output logic [15:0] mosi_bits, output int done_t, output int dones,
                          output logic [15:0] rx, output logic mosi_after, output logic busy0);
      logic prev;
      int   stop_t;
      first_rise = -1; period = -1; rises = 0; mosi_bits = 16'h0000;
      done_t = -1; dones = 0; rx = 16'hxxxx; mosi_after = 1'b0; busy0 = 1'b0;
      prev = 1'b0; stop_t = budget;
      for (int t = 0; t < stop_t; t++) begin
         @(negedge clk);
         if (t == 0) busy0 = bus.BUSY;
         if (bus.SCLK && !prev) begin
            if (rises == 0) first_rise = t;
            else if (rises == 1) period = t - first_rise;
            rises++;
            mosi_bits = {mosi_bits[14:0], bus.MOSI};
         end
         prev = bus.SCLK;
         if (bus.DONE) begin
            dones++;
            if (done_t < 0) begin
               done_t     = t;
               rx         = bus.RX_DATA;
               mosi_after = bus.MOSI;
               stop_t     = t + 4;
            end
         end
         if (disturb && t == 5) begin
            bus.START   = 1'b1;
            bus.TX_DATA = 16'hFFFF;
            bus.DIV     = 8'd0;
            bus.WIDE    = 1'b1;
         end
         if (disturb && t == 6) bus.START = 1'b0;
      end
   endtask

   initial begin
      int          fr, per, rs, dt, dn, cnt;
      logic [15:0] mb, rx;
      logic        ma, b0;

      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; loop_en = 1'b0; miso_tie = 1'b0;
      bus.START = 1'b0; bus.ABORT = 1'b0; bus.WIDE = 1'b0;
      bus.DIV = 8'd0; bus.TX_DATA = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("reset_sclk", 32'(bus.SCLK), 32'd0);
      check("reset_mosi", 32'(bus.MOSI), 32'd1);
      check("reset_busy", 32'(bus.BUSY), 32'd0);
      check("reset_done", 32'(bus.DONE), 32'd0);
      check("reset_rx",   32'(bus.RX_DATA), 32'h0000);

      // byte, DIV=0, loopback
      loop_en = 1'b1;
      start_xfer(1'b0, 8'd0, 16'h00A5);
      monitor(100, 1'b0, fr, per, rs, mb, dt, dn, rx, ma, b0);
      check("byte_busy0",  32'(b0), 32'd1);
      check("byte_rise0",  32'(fr), 32'd1);
      check("byte_period", 32'(per), 32'd2);
      check("byte_rises",  32'(rs), 32'd8);
      check("byte_mosi",   32'(mb), 32'h00A5);
      check("byte_done_t", 32'(dt), 32'd16);
      check("byte_dones",  32'(dn), 32'd1);
      check("byte_rx",     32'(rx), 32'h00A5);

      // word, DIV=3, MISO tied high
      loop_en = 1'b0; miso_tie = 1'b1;
      start_xfer(1'b1, 8'd3, 16'hC33C);
      monitor(300, 1'b0, fr, per, rs, mb, dt, dn, rx, ma, b0);
      check("word_rise0",  32'(fr), 32'd4);
      check("word_period", 32'(per), 32'd8);
      check("word_rises",  32'(rs), 32'd16);
      check("word_mosi",   32'(mb), 32'hC33C);
      check("word_done_t", 32'(dt), 32'd128);
      check("word_dones",  32'(dn), 32'd1);
      check("word_rx",     32'(rx), 32'hFFFF);
      check("word_mosi_after", 32'(ma), 32'd1);

      // byte with upper TX bits set, inputs disturbed mid-transfer
      loop_en = 1'b1;
      start_xfer(1'b0, 8'd1, 16'h7E3C);
      monitor(200, 1'b1, fr, per, rs, mb, dt, dn, rx, ma, b0);
      check("dist_rise0",  32'(fr), 32'd2);
      check("dist_rises",  32'(rs), 32'd8);
      check("dist_mosi",   32'(mb), 32'h003C);
      check("dist_done_t", 32'(dt), 32'd32);
      check("dist_dones",  32'(dn), 32'd1);
      check("dist_rx",     32'(rx), 32'h003C);

      // ABORT mid-byte while SCLK is high and MOSI low
      start_xfer(1'b0, 8'd2, 16'h0001);
      repeat (11) @(negedge clk);
      check("abort_pre_sclk", 32'(bus.SCLK), 32'd1);
      check("abort_pre_mosi", 32'(bus.MOSI), 32'd0);
      bus.ABORT = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(bus.BUSY), 32'd0);
      check("abort_sclk", 32'(bus.SCLK), 32'd0);
      check("abort_mosi", 32'(bus.MOSI), 32'd1);
      check("abort_done", 32'(bus.DONE), 32'd0);
      check("abort_rx",   32'(bus.RX_DATA), 32'h003C);
      bus.ABORT = 1'b0;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.DONE || bus.BUSY) cnt++;
      end
      check("abort_quiet", 32'(cnt), 32'd0);

      // ABORT and START together in IDLE
      bus.ABORT = 1'b1; bus.START = 1'b1;
      @(negedge clk);
      check("abst_busy", 32'(bus.BUSY), 32'd0);
      check("abst_mosi", 32'(bus.MOSI), 32'd1);
      bus.ABORT = 1'b0; bus.START = 1'b0;
      repeat (3) @(negedge clk);
      check("abst_busy_later", 32'(bus.BUSY), 32'd0);

      // reset at bit 5 of a byte, then a slow DIV=124 transfer
      loop_en = 1'b0; miso_tie = 1'b0;
      start_xfer(1'b0, 8'd0, 16'h0000);
      repeat (12) @(negedge clk);
      check("rst_pre_sclk", 32'(bus.SCLK), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_sclk", 32'(bus.SCLK), 32'd0);
      check("rst_mosi", 32'(bus.MOSI), 32'd1);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_rx",   32'(bus.RX_DATA), 32'h0000);
      @(negedge clk) rst_n = 1'b1;
      loop_en = 1'b1;
      start_xfer(1'b0, 8'd124, 16'h0096);
      monitor(2200, 1'b0, fr, per, rs, mb, dt, dn, rx, ma, b0);
      check("slow_rise0",  32'(fr), 32'd125);
      check("slow_period", 32'(per), 32'd250);
      check("slow_rises",  32'(rs), 32'd8);
      check("slow_done_t", 32'(dt), 32'd2000);
      check("slow_rx",     32'(rx), 32'h0096);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
